// File: rtl/fft_pkg.sv
// fft_pkg: datapath widths shared by the FFT/IFFT butterflies and the
// round-half-up shift with signed saturation used at every output stage.
package fft_pkg;
    localparam int DW  = 32;
    localparam int TW  = 16;
    localparam int Q15 = 15;
    localparam int PW  = DW + TW + 2;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          sat;
    } rs_t;

    function automatic rs_t rnd_sat(input logic signed [PW-1:0] x, input int k, input int w);
        logic signed [PW:0] t;
        logic signed [PW:0] hi;
        logic signed [PW:0] lo;
        rs_t r;
        t = (PW+1)'(x);
        if (k > 0) t = (t + ((PW+1)'(1) <<< (k - 1))) >>> k;
        hi = ((PW+1)'(1) <<< (w - 1)) - (PW+1)'(1);
        lo = -hi - (PW+1)'(1);
        r.sat = (t > hi) || (t < lo);
        r.res = (t > hi) ? hi[DW-1:0] : (t < lo) ? lo[DW-1:0] : t[DW-1:0];
        return r;
    endfunction
endpackage

// File: rtl/ifft_dif_butterfly_pipe_if.sv
// ifft_dif_butterfly_pipe_if: valid/ready beat bus of the IFFT DIF butterfly,
// input operands with tag, results with tag, and the saturation status.
interface ifft_dif_butterfly_pipe_if
    import fft_pkg::*;
#(
    parameter int TAGW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic [TAGW-1:0]      in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out1r, out1i, out2r, out2i;
    logic [TAGW-1:0]      out_tag;
    logic                 sat_sticky;
    logic                 sat_clr;

    modport slave (
        input  in_valid, ar, ai, br, bi, wr, wi, in_tag, out_ready, sat_clr,
        output in_ready, out_valid, out1r, out1i, out2r, out2i, out_tag, sat_sticky
    );

    modport master (
        output in_valid, ar, ai, br, bi, wr, wi, in_tag, out_ready, sat_clr,
        input  in_ready, out_valid, out1r, out1i, out2r, out2i, out_tag, sat_sticky
    );
endinterface

// File: rtl/cplx_conj_mult.sv
// cplx_conj_mult: registered full-precision product d * conj(w), w in Q1.15.
module cplx_conj_mult
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic signed [DW:0]   i_dr,
    input  logic signed [DW:0]   i_di,
    input  logic signed [TW-1:0] i_wr,
    input  logic signed [TW-1:0] i_wi,
    output logic signed [PW-1:0] o_pr,
    output logic signed [PW-1:0] o_pi
);
    logic signed [PW-1:0] w_pr, w_pi;

    // Operands widened first so the -1.0 twiddle stays exact.
    assign w_pr = PW'(i_dr) * PW'(i_wr) + PW'(i_di) * PW'(i_wi);
    assign w_pi = PW'(i_di) * PW'(i_wr) - PW'(i_dr) * PW'(i_wi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pr <= '0;
            o_pi <= '0;
        end else if (i_en) begin
            o_pr <= w_pr;
            o_pi <= w_pi;
        end
    end
endmodule

// File: rtl/ifft_dif_butterfly_pipe.sv
// ifft_dif_butterfly_pipe: 3-stage radix-2 DIF butterfly for the inverse FFT,
// out1 = (a+b)/s, out2 = (a-b)*conj(W)/s, valid/ready with a carried tag.
module ifft_dif_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int TAGW  = 8,
    parameter bit SCALE = 1'b1
) (
    input logic clk,
    input logic rst_n,
    ifft_dif_butterfly_pipe_if.slave io_bus
);
    localparam int KS = int'(SCALE);
    localparam int KD = Q15 + KS;

    logic                 w_en, w_sat;
    logic                 r_v1, r_v2, r_v3;
    logic signed [DW:0]   r_sr, r_si, r_dr, r_di, r_sr2, r_si2;
    logic signed [TW-1:0] r_wr, r_wi;
    logic [TAGW-1:0]      r_tag1, r_tag2;
    logic signed [PW-1:0] w_pr, w_pi;
    rs_t                  w_o1r, w_o1i, w_o2r, w_o2i;

    // The whole pipe moves as one; a bubble in S3 never blocks the input.
    assign w_en             = !r_v3 || io_bus.out_ready;
    assign io_bus.in_ready  = w_en;
    assign io_bus.out_valid = r_v3;

    assign w_o1r = rnd_sat(PW'(r_sr2), KS, DW);
    assign w_o1i = rnd_sat(PW'(r_si2), KS, DW);
    assign w_o2r = rnd_sat(w_pr, KD, DW);
    assign w_o2i = rnd_sat(w_pi, KD, DW);
    assign w_sat = w_o1r.sat | w_o1i.sat | w_o2r.sat | w_o2i.sat;

    cplx_conj_mult u_mult (
        .clk  (clk),
        .rst_n(rst_n),
        .i_en (w_en),
        .i_dr (r_dr),
        .i_di (r_di),
        .i_wr (r_wr),
        .i_wi (r_wi),
        .o_pr (w_pr),
        .o_pi (w_pi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_v1, r_v2, r_v3} <= '0;
            {r_sr, r_si, r_dr, r_di, r_sr2, r_si2} <= '0;
            {r_wr, r_wi, r_tag1, r_tag2} <= '0;
            {io_bus.out1r, io_bus.out1i, io_bus.out2r, io_bus.out2i} <= '0;
            io_bus.out_tag <= '0;
        end else if (w_en) begin
            r_v1           <= io_bus.in_valid;
            r_v2           <= r_v1;
            r_v3           <= r_v2;
            r_sr           <= (DW+1)'(io_bus.ar) + (DW+1)'(io_bus.br);
            r_si           <= (DW+1)'(io_bus.ai) + (DW+1)'(io_bus.bi);
            r_dr           <= (DW+1)'(io_bus.ar) - (DW+1)'(io_bus.br);
            r_di           <= (DW+1)'(io_bus.ai) - (DW+1)'(io_bus.bi);
            r_wr           <= io_bus.wr;
            r_wi           <= io_bus.wi;
            r_tag1         <= io_bus.in_tag;
            r_sr2          <= r_sr;
            r_si2          <= r_si;
            r_tag2         <= r_tag1;
            io_bus.out1r   <= w_o1r.res;
            io_bus.out1i   <= w_o1i.res;
            io_bus.out2r   <= w_o2r.res;
            io_bus.out2i   <= w_o2i.res;
            io_bus.out_tag <= r_tag2;
        end
    end

    // A saturation landing in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) io_bus.sat_sticky <= 1'b0;
        else if (w_en && r_v2 && w_sat) io_bus.sat_sticky <= 1'b1;
        else if (io_bus.sat_clr) io_bus.sat_sticky <= 1'b0;
    end
endmodule
